// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with a mid-packet stall watchdog.
// Define AXIS_ARB_SRC_TAG_EN to overwrite M_AXIS_TUSER[7:0] with the granted port index.
module axis_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int USER_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [NUM_PORTS-1:0]          S_AXIS_TVALID,
  output logic [NUM_PORTS-1:0]          S_AXIS_TREADY,
  input  logic [NUM_PORTS*64-1:0]       S_AXIS_TDATA,
  input  logic [NUM_PORTS-1:0]          S_AXIS_TLAST,
  input  logic [NUM_PORTS*USER_W-1:0]   S_AXIS_TUSER,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [63:0]                   M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic [USER_W-1:0]             M_AXIS_TUSER,
  output logic [NUM_PORTS-1:0]          GRANT,
  output logic                          BUSY,
  output logic                          STALL_ERR
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, TERM, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [63:0]        tdata_a [NUM_PORTS];
  logic [USER_W-1:0]  tuser_a [NUM_PORTS];
  logic [IDX_W-1:0]   sel_idx, scan_idx, gnext;
  logic               sel_vld, stall_hit;
  logic [USER_W-1:0]  user_mux, term_user;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign tdata_a[p] = S_AXIS_TDATA[64*p +: 64];
    assign tuser_a[p] = S_AXIS_TUSER[USER_W*p +: USER_W];
  end

`ifdef AXIS_ARB_SRC_TAG_EN
  assign user_mux  = (tuser_a[gidx_q] & ~USER_W'(8'hFF)) | USER_W'(gidx_q);
  assign term_user = USER_W'(gidx_q);
`else
  assign user_mux  = tuser_a[gidx_q];
  assign term_user = '0;
`endif

  assign gnext     = (gidx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
  assign stall_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  assign BUSY      = (state_q != IDLE);
  assign STALL_ERR = err_q;

  // First requesting port at or after ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    sel_idx  = '0;
    sel_vld  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (!sel_vld && S_AXIS_TVALID[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  always_comb begin
    GRANT = '0;
    if (state_q != IDLE) GRANT[gidx_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    S_AXIS_TREADY = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gidx_d  = sel_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Termination takes priority over a beat arriving on the expiry cycle.
        if (stall_hit) begin
          state_d = TERM;
        end else begin
          M_AXIS_TVALID          = S_AXIS_TVALID[gidx_q];
          M_AXIS_TDATA           = tdata_a[gidx_q];
          M_AXIS_TLAST           = S_AXIS_TLAST[gidx_q];
          M_AXIS_TUSER           = user_mux;
          S_AXIS_TREADY[gidx_q]  = M_AXIS_TREADY;
          if (TIMEOUT != 0) cnt_d = S_AXIS_TVALID[gidx_q] ? '0 : cnt_q + 1'b1;
          if (S_AXIS_TVALID[gidx_q] && M_AXIS_TREADY && S_AXIS_TLAST[gidx_q]) begin
            ptr_d   = gnext;
            state_d = IDLE;
          end
        end
      end
      TERM: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        M_AXIS_TUSER  = term_user;
        if (M_AXIS_TREADY) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        S_AXIS_TREADY[gidx_q] = 1'b1;
        if (S_AXIS_TVALID[gidx_q] && S_AXIS_TLAST[gidx_q]) begin
          ptr_d   = gnext;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
